// File: rtl/decode_ctrl_pipe_if.sv
// ----------------------------------------------------------------------------
// decode_ctrl_pipe_if
//   Bundles the ID-side handshake and the registered EX control outputs of
//   decode_ctrl_pipe. GPIO_CH must match the GPIO_CH of the attached stage.
//
//   Handshake: an instruction in ID transfers into EX at a rising edge when
//   valid_ID && ready_ID are both high in the preceding cycle. valid_ID may
//   be raised at any time and is expected to hold instr_ID stable until the
//   transfer. ready_ID is combinational and drops for flush, stall_EX, or
//   a HI/LO hazard.
//
//   master : upstream/fetch side (drives instr_ID, valid_ID, stall_EX, flush)
//   slave  : the decode stage (drives ready_ID and all *_EX outputs)
// ----------------------------------------------------------------------------
interface decode_ctrl_pipe_if #(
    parameter int GPIO_CH = 4
);
    logic [31:0]        instr_ID;
    logic               valid_ID;
    logic               ready_ID;
    logic               stall_EX;
    logic               flush;
    logic               valid_EX;
    logic [3:0]         alu_op_EX;
    logic [4:0]         shamt_EX;
    logic               enhilo_EX;
    logic [1:0]         regsel_EX;
    logic               regwrite_EX;
    logic               rdrt_EX;
    logic               memwrite_EX;
    logic [1:0]         alu_src_EX;
    logic [GPIO_CH-1:0] gpio_out_EX;
    logic [GPIO_CH-1:0] gpio_in_EX;
    logic               illegal_EX;
    logic               hilo_busy;

    modport master (
        output instr_ID, valid_ID, stall_EX, flush,
        input  ready_ID, valid_EX, alu_op_EX, shamt_EX, enhilo_EX, regsel_EX,
               regwrite_EX, rdrt_EX, memwrite_EX, alu_src_EX, gpio_out_EX,
               gpio_in_EX, illegal_EX, hilo_busy
    );

    modport slave (
        input  instr_ID, valid_ID, stall_EX, flush,
        output ready_ID, valid_EX, alu_op_EX, shamt_EX, enhilo_EX, regsel_EX,
               regwrite_EX, rdrt_EX, memwrite_EX, alu_src_EX, gpio_out_EX,
               gpio_in_EX, illegal_EX, hilo_busy
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// ----------------------------------------------------------------------------
// decode_ctrl_pipe
//   ID->EX decode/control stage for the MIPS-subset pipeline. Decodes one
//   instruction per cycle into a registered EX control bundle, tracks a
//   pending multiplier result (HI/LO scoreboard) and maps shamt==0 SRL/SRA
//   onto GPIO write/read channels.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - decode_ctrl_pipe_if.slave: ID handshake in, EX bundle out,
//            hilo_busy (scoreboard counter non-zero)
// ----------------------------------------------------------------------------
module decode_ctrl_pipe #(
    parameter int GPIO_CH  = 4,
    parameter int MULT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    decode_ctrl_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(MULT_LAT + 1);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_NOR   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0101;
    localparam logic [3:0] ALU_MULT  = 4'b0110;
    localparam logic [3:0] ALU_MULTU = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_SLT   = 4'b1100;
    localparam logic [3:0] ALU_SLTU  = 4'b1101;

    typedef struct packed {
        logic [3:0]         alu_op;
        logic [4:0]         shamt;
        logic               enhilo;
        logic [1:0]         regsel;
        logic               regwrite;
        logic               rdrt;
        logic               memwrite;
        logic [1:0]         alu_src;
        logic [GPIO_CH-1:0] gpio_out;
        logic [GPIO_CH-1:0] gpio_in;
        logic               illegal;
    } ctrl_t;

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs_f;
    logic [4:0]         sh_f;
    logic [GPIO_CH-1:0] ch_onehot;
    logic               ch_ok;
    ctrl_t              dec;
    logic               dec_mult;
    logic               dec_hilo;
    logic               bad;
    ctrl_t              ex_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt;
    logic               hilo_busy;
    logic               hazard;
    logic               ready;
    logic               accept;

    assign op    = bus.instr_ID[31:26];
    assign rs_f  = bus.instr_ID[25:21];
    assign sh_f  = bus.instr_ID[10:6];
    assign funct = bus.instr_ID[5:0];

    // GPIO channel comes from the rs field; out-of-range shifts to zero.
    assign ch_onehot = GPIO_CH'(1) << rs_f;
    assign ch_ok     = (32'(rs_f) < 32'(GPIO_CH));

    always_comb begin
        dec      = '0;
        dec_mult = 1'b0;
        dec_hilo = 1'b0;
        bad      = 1'b0;
        if (bus.instr_ID == 32'd0) begin
            // NOP: valid slot, everything disabled.
        end else if (op == 6'b000000) begin
            dec.regwrite = 1'b1;
            case (funct)
                6'b100000, 6'b100001: dec.alu_op = ALU_ADD;
                6'b100010, 6'b100011: dec.alu_op = ALU_SUB;
                6'b011000, 6'b011001: begin
                    dec.alu_op   = funct[0] ? ALU_MULTU : ALU_MULT;
                    dec.enhilo   = 1'b1;
                    dec.regwrite = 1'b0;
                    dec_mult     = 1'b1;
                    dec_hilo     = 1'b1;
                end
                6'b100100: dec.alu_op = ALU_AND;
                6'b100101: dec.alu_op = ALU_OR;
                6'b100111: dec.alu_op = ALU_NOR;
                6'b100110: dec.alu_op = ALU_XOR;
                6'b000000: begin
                    dec.alu_op = ALU_SLL;
                    dec.shamt  = sh_f;
                end
                6'b000010: begin
                    // shamt==0 SRL doubles as a GPIO write.
                    dec.alu_op = ALU_SRL;
                    dec.shamt  = sh_f;
                    if (sh_f == 5'd0) begin
                        if (ch_ok) dec.gpio_out = ch_onehot;
                        else       bad = 1'b1;
                    end
                end
                6'b000011: begin
                    // shamt==0 SRA doubles as a GPIO read into the regfile.
                    dec.alu_op = ALU_SRA;
                    dec.shamt  = sh_f;
                    if (sh_f == 5'd0) begin
                        if (ch_ok) begin
                            dec.gpio_in = ch_onehot;
                            dec.regsel  = 2'd3;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                6'b010000: begin
                    dec.regsel = 2'd1;
                    dec_hilo   = 1'b1;
                end
                6'b010010: begin
                    dec.regsel = 2'd2;
                    dec_hilo   = 1'b1;
                end
                6'b101010: dec.alu_op = ALU_SLT;
                6'b101011: dec.alu_op = ALU_SLTU;
                default:   bad = 1'b1;
            endcase
        end else begin
            dec.rdrt     = 1'b1;
            dec.regwrite = 1'b1;
            case (op)
                6'b001000, 6'b001001: begin
                    dec.alu_op  = ALU_ADD;
                    dec.alu_src = 2'd1;
                end
                6'b001010: begin
                    dec.alu_op  = ALU_SLT;
                    dec.alu_src = 2'd1;
                end
                6'b001100: begin
                    dec.alu_op  = ALU_AND;
                    dec.alu_src = 2'd2;
                end
                6'b001101: begin
                    dec.alu_op  = ALU_OR;
                    dec.alu_src = 2'd2;
                end
                6'b001110: begin
                    dec.alu_op  = ALU_XOR;
                    dec.alu_src = 2'd2;
                end
                6'b001111: begin
                    dec.alu_op  = ALU_SLL;
                    dec.shamt   = 5'd16;
                    dec.alu_src = 2'd2;
                end
                default: bad = 1'b1;
            endcase
        end
        // Illegal encodings carry only the flag so nothing downstream fires.
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign hilo_busy = (cnt != '0);
    assign hazard    = bus.valid_ID && dec_hilo && hilo_busy;
    assign ready     = !bus.flush && !bus.stall_EX && !hazard;
    assign accept    = bus.valid_ID && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (bus.flush) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (bus.stall_EX) begin
            ex_q    <= ex_q;
            valid_q <= valid_q;
        end else if (accept) begin
            ex_q    <= dec;
            valid_q <= 1'b1;
        end else begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end
    end

    // A mult is never accepted while busy, so the load only happens from 0.
    // Flush leaves the counter running: a killed mult just idles HI/LO longer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept && dec_mult) begin
            cnt <= CNT_W'(MULT_LAT);
        end else if (hilo_busy && !bus.stall_EX) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign bus.ready_ID    = ready;
    assign bus.valid_EX    = valid_q;
    assign bus.alu_op_EX   = ex_q.alu_op;
    assign bus.shamt_EX    = ex_q.shamt;
    assign bus.enhilo_EX   = ex_q.enhilo;
    assign bus.regsel_EX   = ex_q.regsel;
    assign bus.regwrite_EX = ex_q.regwrite;
    assign bus.rdrt_EX     = ex_q.rdrt;
    assign bus.memwrite_EX = ex_q.memwrite;
    assign bus.alu_src_EX  = ex_q.alu_src;
    assign bus.gpio_out_EX = ex_q.gpio_out;
    assign bus.gpio_in_EX  = ex_q.gpio_in;
    assign bus.illegal_EX  = ex_q.illegal;
    assign bus.hilo_busy   = hilo_busy;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;
    localparam int GPIO_CH  = 4;
    localparam int MULT_LAT = 3;
    localparam int EXW      = 27;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [EXW-1:0] exp_q[$];

    decode_ctrl_pipe_if #(.GPIO_CH(GPIO_CH)) bus ();

    decode_ctrl_pipe #(.GPIO_CH(GPIO_CH), .MULT_LAT(MULT_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [EXW-1:0] ex_word();
        return {bus.valid_EX, bus.alu_op_EX, bus.shamt_EX, bus.enhilo_EX,
                bus.regsel_EX, bus.regwrite_EX, bus.rdrt_EX, bus.memwrite_EX,
                bus.alu_src_EX, bus.gpio_out_EX, bus.gpio_in_EX, bus.illegal_EX};
    endfunction

    function automatic logic [EXW-1:0] mk(input logic [3:0] alu, input logic [4:0] sh,
                                          input logic hl, input logic [1:0] rsel,
                                          input logic rw, input logic rdrt,
                                          input logic [1:0] src, input logic [3:0] go,
                                          input logic [3:0] gi, input logic ill);
        return {1'b1, alu, sh, hl, rsel, rw, rdrt, 1'b0, src, go, gi, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input string tag, input logic [31:0] ins, input logic [EXW-1:0] exp);
        bus.instr_ID = ins;
        bus.valid_ID = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(bus.ready_ID), 32'd1);
        exp_q.push_back(exp);
        @(negedge clk);
        bus.valid_ID = 1'b0;
        check({tag, "_ex"}, 32'(ex_word()), 32'(exp_q.pop_front()));
    endtask

    // mult then mfhi; count cycles mfhi is held off, optionally stalling 2 of them.
    task automatic mult_then_mfhi(input string tag, input bit use_stall, input int exp_waits);
        int   waits;
        logic busy_ok;
        issue({tag, "_mult"}, 32'h01090018, mk(4'b0110, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        check({tag, "_busy0"}, 32'(bus.hilo_busy), 32'd1);
        bus.instr_ID = 32'h00005010;
        bus.valid_ID = 1'b1;
        waits   = 0;
        busy_ok = 1'b1;
        while (waits < 20) begin
            bus.stall_EX = use_stall && (waits == 1 || waits == 2);
            #1;
            if (bus.ready_ID) break;
            busy_ok &= bus.hilo_busy;
            @(negedge clk);
            waits++;
        end
        bus.stall_EX = 1'b0;
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_done"}, 32'(bus.hilo_busy), 32'd0);
        exp_q.push_back(mk(4'b0000, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        @(negedge clk);
        bus.valid_ID = 1'b0;
        check({tag, "_mfhi_ex"}, 32'(ex_word()), 32'(exp_q.pop_front()));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [EXW-1:0] lui_w;
        n_cmp = 0;
        n_err = 0;
        lui_w = mk(4'b1000, 5'd16, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd0, 4'd0, 1'b0);

        // Reset held 3 cycles with a valid instruction waiting.
        rst          = 1'b0;
        bus.instr_ID = 32'h01095020;
        bus.valid_ID = 1'b1;
        bus.stall_EX = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ex", 32'(ex_word()), 32'd0);
        check("reset_busy", 32'(bus.hilo_busy), 32'd0);
        rst = 1'b1;
        issue("add", 32'h01095020, mk(4'b0100, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        @(negedge clk);
        check("bubble_after_add", 32'(bus.valid_EX), 32'd0);

        // I-types and assorted R-types.
        issue("lui",   32'h3C0A1234, lui_w);
        issue("addi",  32'h2108FFFF, mk(4'b0100, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'd0, 4'd0, 1'b0));
        issue("ori",   32'h3508FFFF, mk(4'b0001, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd0, 4'd0, 1'b0));
        issue("nop",   32'h00000000, mk(4'b0000, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        issue("sll4",  32'h00095100, mk(4'b1000, 5'd4, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        issue("srl3",  32'h000950C2, mk(4'b1001, 5'd3, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        issue("slt",   32'h0109502A, mk(4'b1100, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));

        // GPIO map.
        issue("gpio_wr2", 32'h00485002, mk(4'b1001, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0100, 4'd0, 1'b0));
        issue("gpio_rd1", 32'h00205003, mk(4'b1010, 5'd0, 1'b0, 2'd3, 1'b1, 1'b0, 2'd0, 4'd0, 4'b0010, 1'b0));
        issue("gpio_wr5", 32'h00A05002, mk(4'b0000, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1));
        issue("illegal_op", 32'hFC000000, mk(4'b0000, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1));

        // HI/LO scoreboard, plain and with a 2-cycle stall in the wait.
        mult_then_mfhi("sb", 1'b0, MULT_LAT);
        mult_then_mfhi("sb_stall", 1'b1, MULT_LAT + 2);

        // Flush with valid_ID: not accepted, EX becomes a bubble.
        @(negedge clk);
        bus.instr_ID = 32'h01095020;
        bus.valid_ID = 1'b1;
        bus.flush    = 1'b1;
        #1;
        check("flush_ready", 32'(bus.ready_ID), 32'd0);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.valid_ID = 1'b0;
        check("flush_ex", 32'(ex_word()), 32'd0);

        // Flushing a mult in EX leaves the scoreboard running.
        issue("fmult", 32'h01090018, mk(4'b0110, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fmult_valid", 32'(bus.valid_EX), 32'd0);
        check("fmult_busy", 32'(bus.hilo_busy), 32'd1);
        repeat (3) @(negedge clk);
        check("fmult_busy_end", 32'(bus.hilo_busy), 32'd0);

        // Stall for 4 cycles with a waiting instruction: EX holds lui.
        issue("lui2", 32'h3C0A1234, lui_w);
        bus.stall_EX = 1'b1;
        bus.instr_ID = 32'h01095020;
        bus.valid_ID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("stall_ready%0d", i), 32'(bus.ready_ID), 32'd0);
            @(negedge clk);
            check($sformatf("stall_hold%0d", i), 32'(ex_word()), 32'(lui_w));
        end
        bus.stall_EX = 1'b0;
        issue("add_after_stall", 32'h01095020, mk(4'b0100, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));

        // Asynchronous reset mid-stream clears EX and the scoreboard at once.
        issue("rmult", 32'h01090018, mk(4'b0110, 5'd0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ex", 32'(ex_word()), 32'd0);
        check("async_rst_busy", 32'(bus.hilo_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- final report ----------------
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
